// File: rtl/i_cache_axi_refill_pkg.sv
// Shared encodings and AXI4 constants for the i-cache refill responder.
package i_cache_axi_refill_pkg;

  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StAr   = 4'b0010,
    StR    = 4'b0100,
    StResp = 4'b1000
  } refill_state_e;

  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [2:0]  SIZE_4B     = 3'b010;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [31:0] INSN_NOP    = 32'h0000_0013;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/i_cache_axi_refill.sv
// Single-beat AXI4 read responder for i-cache refills.
// Optional ICACHE_REFILL_RESP_ERR_EN adds cache_err and NOP substitution on SLVERR/DECERR.
module i_cache_axi_refill
  import i_cache_axi_refill_pkg::*;
#(
  parameter int unsigned AXI_ID_W   = 4,
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned AXI_ADDR_W = 64,
  parameter int unsigned AXI_DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_read_ena,
  input  logic [63:0]           cache_addr,
  output logic [31:0]           cache_or_data,
  output logic                  cache_in_ok,
`ifdef ICACHE_REFILL_RESP_ERR_EN
  output logic                  cache_err,
`endif
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [AXI_ADDR_W-1:0] axi_araddr,
  output logic [AXI_ID_W-1:0]   axi_arid,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [AXI_DATA_W-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  input  logic [AXI_ID_W-1:0]   axi_rid
);

  refill_state_e r_state;
  logic [63:0]   r_addr;
  logic          r_armed;
  logic          r_drop;
  logic          r_arvalid;
  logic          r_rready;
  logic          r_in_ok;
  logic [31:0]   r_data;

  logic          w_hit;
  logic          w_drop_nxt;
  logic [31:0]   w_lane;
  logic [31:0]   w_word;
  logic          w_unused;

  assign w_hit      = axi_rvalid & r_rready & axi_rlast & (axi_rid == AXI_ID_W'(AXI_ID));
  // A withdrawal sampled on the capture edge itself must also suppress the pulse.
  assign w_drop_nxt = r_drop | ~cache_read_ena;
  assign w_lane     = r_addr[2] ? axi_rdata[63:32] : axi_rdata[31:0];

`ifdef ICACHE_REFILL_RESP_ERR_EN
  logic r_err;
  logic w_err;

  assign w_err     = resp_is_err(axi_rresp);
  assign w_word    = w_err ? INSN_NOP : w_lane;
  assign cache_err = r_err;
  assign w_unused  = ^r_addr[1:0];
`else
  assign w_word   = w_lane;
  assign w_unused = ^{axi_rresp, r_addr[1:0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_armed   <= 1'b1;
      r_drop    <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_in_ok   <= 1'b0;
      r_data    <= '0;
`ifdef ICACHE_REFILL_RESP_ERR_EN
      r_err     <= 1'b0;
`endif
    end else begin
      if (r_state != StResp && !cache_read_ena) r_armed <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (cache_read_ena && r_armed) begin
            r_addr    <= cache_addr;
            r_drop    <= 1'b0;
            r_arvalid <= 1'b1;
            r_state   <= StAr;
          end
        end
        StAr: begin
          if (!cache_read_ena) r_drop <= 1'b1;
          if (axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StR;
          end
        end
        StR: begin
          if (!cache_read_ena) r_drop <= 1'b1;
          if (w_hit) begin
            r_rready <= 1'b0;
            r_data   <= w_word;
            r_in_ok  <= ~w_drop_nxt;
`ifdef ICACHE_REFILL_RESP_ERR_EN
            r_err    <= w_err & ~w_drop_nxt;
`endif
            r_state  <= StResp;
          end
        end
        StResp: begin
          // Requires a low sample of the request before the next refill is accepted.
          r_armed <= 1'b0;
          r_in_ok <= 1'b0;
`ifdef ICACHE_REFILL_RESP_ERR_EN
          r_err   <= 1'b0;
`endif
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cache_or_data = r_data;
  assign cache_in_ok   = r_in_ok;
  assign axi_arvalid   = r_arvalid;
  assign axi_araddr    = AXI_ADDR_W'({r_addr[63:2], 2'b00});
  assign axi_arid      = AXI_ID_W'(AXI_ID);
  assign axi_arlen     = 8'd0;
  assign axi_arsize    = SIZE_4B;
  assign axi_arburst   = BURST_INCR;
  assign axi_rready    = r_rready;

endmodule

// File: tb/tb_i_cache_axi_refill.sv
// Directed, table-driven bench for i_cache_axi_refill (honours ICACHE_REFILL_RESP_ERR_EN).
module tb_i_cache_axi_refill;
  import i_cache_axi_refill_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cache_read_ena;
  logic [63:0] cache_addr;
  logic [31:0] cache_or_data;
  logic        cache_in_ok;
`ifdef ICACHE_REFILL_RESP_ERR_EN
  logic        cache_err;
`endif
  logic        axi_arvalid;
  logic        axi_arready;
  logic [63:0] axi_araddr;
  logic [3:0]  axi_arid;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic [3:0]  axi_rid;

  int n_cmp = 0;
  int n_err = 0;
  int ok_pulses = 0;
  int r_handshakes = 0;

  always #5 clk = ~clk;

  i_cache_axi_refill dut (
    .clk            (clk),
    .rst            (rst),
    .cache_read_ena (cache_read_ena),
    .cache_addr     (cache_addr),
    .cache_or_data  (cache_or_data),
    .cache_in_ok    (cache_in_ok),
`ifdef ICACHE_REFILL_RESP_ERR_EN
    .cache_err      (cache_err),
`endif
    .axi_arvalid    (axi_arvalid),
    .axi_arready    (axi_arready),
    .axi_araddr     (axi_araddr),
    .axi_arid       (axi_arid),
    .axi_arlen      (axi_arlen),
    .axi_arsize     (axi_arsize),
    .axi_arburst    (axi_arburst),
    .axi_rvalid     (axi_rvalid),
    .axi_rready     (axi_rready),
    .axi_rdata      (axi_rdata),
    .axi_rresp      (axi_rresp),
    .axi_rlast      (axi_rlast),
    .axi_rid        (axi_rid)
  );

  always @(negedge clk) begin
    if (cache_in_ok) ok_pulses++;
    if (axi_rvalid && axi_rready) r_handshakes++;
  end

  typedef struct {
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    int          ar_wait;
    int          r_wait;
    bit          withdraw;
    logic [63:0] exp_araddr;
    logic [31:0] exp_data;
    bit          exp_ok;
    bit          exp_err;
  } vec_t;

`ifdef ICACHE_REFILL_RESP_ERR_EN
  localparam logic [31:0] ERR_DATA = 32'h0000_0013;
  localparam bit          ERR_FLAG = 1'b1;
`else
  localparam logic [31:0] ERR_DATA = 32'h7777_8888;
  localparam bit          ERR_FLAG = 1'b0;
`endif

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int p0;
    int h0;
    p0 = ok_pulses;
    h0 = r_handshakes;
    cache_addr     = v.addr;
    cache_read_ena = 1'b1;
    step();
    check("arvalid", axi_arvalid, 1);
    check("araddr", axi_araddr, v.exp_araddr);
    for (int i = 0; i < v.ar_wait; i++) begin
      step();
      check("ar_hold_valid", axi_arvalid, 1);
      check("ar_hold_addr", axi_araddr, v.exp_araddr);
    end
    axi_arready = 1'b1;
    step();
    axi_arready = 1'b0;
    check("rready", axi_rready, 1);
    check("arvalid_drop", axi_arvalid, 0);
    if (v.withdraw) cache_read_ena = 1'b0;
    for (int i = 0; i < v.r_wait; i++) step();
    axi_rvalid = 1'b1;
    axi_rlast  = 1'b1;
    axi_rid    = 4'd0;
    axi_rdata  = v.rdata;
    axi_rresp  = v.rresp;
    step();
    axi_rvalid = 1'b0;
    axi_rresp  = 2'b00;
    check("in_ok", cache_in_ok, v.exp_ok);
    if (v.exp_ok) check("data", cache_or_data, v.exp_data);
`ifdef ICACHE_REFILL_RESP_ERR_EN
    check("err", cache_err, v.exp_err);
`endif
    cache_read_ena = 1'b0;
    step();
    check("in_ok_one_cycle", cache_in_ok, 0);
    step();
    check("idle", dut.r_state == StIdle, 1);
    check("pulse_count", ok_pulses - p0, v.exp_ok);
    check("r_handshake", r_handshakes - h0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{64'h8000_0004, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 0, 0, 1'b0,
                64'h8000_0004, 32'hAAAA_BBBB, 1'b1, 1'b0};
    vecs[1] = '{64'h8000_0000, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 5, 0, 1'b0,
                64'h8000_0000, 32'hCCCC_DDDD, 1'b1, 1'b0};
    vecs[2] = '{64'h0000_1236, 64'h1122_3344_5566_7788, 2'b00, 1, 2, 1'b0,
                64'h0000_1234, 32'h1122_3344, 1'b1, 1'b0};
    vecs[3] = '{64'h8000_0008, 64'h9999_0000_DEAD_BEEF, 2'b00, 0, 4, 1'b1,
                64'h8000_0008, 32'h0, 1'b0, 1'b0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0123_4567_89AB_CDEF, 2'b01, 2, 1, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFC, 32'h0123_4567, 1'b1, 1'b0};
    vecs[5] = '{64'h8000_0010, 64'h5555_6666_7777_8888, 2'b10, 0, 0, 1'b0,
                64'h8000_0010, ERR_DATA, 1'b1, ERR_FLAG};

    rst            = 1'b1;
    cache_read_ena = 1'b0;
    cache_addr     = '0;
    axi_arready    = 1'b0;
    axi_rvalid     = 1'b0;
    axi_rdata      = '0;
    axi_rresp      = 2'b00;
    axi_rlast      = 1'b0;
    axi_rid        = 4'd0;
    step();
    step();
    check("rst_arvalid", axi_arvalid, 0);
    check("rst_rready", axi_rready, 0);
    check("rst_in_ok", cache_in_ok, 0);
    check("rst_data", cache_or_data, 0);
    check("arlen", axi_arlen, 0);
    check("arsize", axi_arsize, 3'b010);
    check("arburst", axi_arburst, 2'b01);
    check("arid", axi_arid, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Re-arm: request held high after completion must not start a second refill.
    cache_addr     = 64'h4000_0000;
    cache_read_ena = 1'b1;
    step();
    check("rearm_arvalid", axi_arvalid, 1);
    axi_arready = 1'b1;
    step();
    axi_arready = 1'b0;
    axi_rvalid  = 1'b1;
    axi_rdata   = 64'h0BAD_F00D_1234_5678;
    step();
    axi_rvalid = 1'b0;
    check("rearm_in_ok", cache_in_ok, 1);
    check("rearm_data", cache_or_data, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rearm_no_dup", axi_arvalid, 0);
    end
    cache_read_ena = 1'b0;
    step();
    check("rearm_low", axi_arvalid, 0);
    cache_addr     = 64'h4000_0004;
    cache_read_ena = 1'b1;
    step();
    check("rearm_new_arvalid", axi_arvalid, 1);
    check("rearm_new_araddr", axi_araddr, 64'h4000_0004);
    axi_arready = 1'b1;
    step();
    axi_arready = 1'b0;
    axi_rvalid  = 1'b1;
    step();
    axi_rvalid = 1'b0;
    check("rearm_new_in_ok", cache_in_ok, 1);
    check("rearm_new_data", cache_or_data, 32'h0BAD_F00D);
    cache_read_ena = 1'b0;
    step();
    step();

    // Mismatched rid is swallowed; the block keeps waiting in R.
    cache_addr     = 64'h8000_0020;
    cache_read_ena = 1'b1;
    step();
    axi_arready = 1'b1;
    step();
    axi_arready = 1'b0;
    axi_rvalid  = 1'b1;
    axi_rid     = 4'd5;
    axi_rdata   = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    check("badid_in_ok", cache_in_ok, 0);
    check("badid_rready", axi_rready, 1);
    axi_rid   = 4'd0;
    axi_rdata = 64'h0000_0001_0000_0002;
    step();
    axi_rvalid = 1'b0;
    check("goodid_in_ok", cache_in_ok, 1);
    check("goodid_data", cache_or_data, 32'h0000_0002);
    cache_read_ena = 1'b0;
    step();
    step();

    // Asynchronous reset while waiting on arready.
    cache_addr     = 64'h8000_0030;
    cache_read_ena = 1'b1;
    step();
    check("prerst_arvalid", axi_arvalid, 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_arvalid", axi_arvalid, 0);
    check("midrst_idle", dut.r_state == StIdle, 1);
    check("midrst_data", cache_or_data, 0);
    step();
    rst            = 1'b0;
    cache_read_ena = 1'b0;
    step();
    run_txn(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i_cache_axi_refill.md
Name: i_cache_axi_refill

Overview:
- Memory-side responder for the instruction-cache refill interface.
- Accepts a level-held refill request (`cache_read_ena`, `cache_addr`) from the i-cache.
- Issues a single-beat AXI4 read on the AR/R channels, returns the selected 32-bit instruction word on `cache_or_data`, and pulses `cache_in_ok` for one cycle.
- Sits between the i-cache and the AXI4 interconnect/arbiter.

Parameters:
- AXI_ID_W, 4, width of `arid`/`rid`.
- AXI_ID, 0, constant ID driven on `arid`; `rid` is checked against it.
- AXI_ADDR_W, 64, AXI address width.
- AXI_DATA_W, 64, AXI read data width; the instruction lane is selected by `addr[2]`.

Ports:
- clk  in  1  single clock; all flops posedge.
- rst  in  1  asynchronous, active-high reset.
- cache_read_ena  in  1  refill request, held high until `cache_in_ok`.
- cache_addr  in  64  instruction byte address; stable while request high.
- cache_or_data  out  32  returned instruction word; valid when `cache_in_ok`=1.
- cache_in_ok  out  1  one-cycle completion pulse.
- axi_arvalid  out  1  AR valid.
- axi_arready  in  1  AR ready.
- axi_araddr  out  AXI_ADDR_W  `{addr[63:2],2'b00}`.
- axi_arid  out  AXI_ID_W  constant AXI_ID.
- axi_arlen  out  8  constant 0.
- axi_arsize  out  3  constant 3'b010 (4 bytes).
- axi_arburst  out  2  constant INCR (2'b01).
- axi_rvalid  in  1  R valid.
- axi_rready  out  1  R ready.
- axi_rdata  in  AXI_DATA_W  read data.
- axi_rresp  in  2  response code.
- axi_rlast  in  1  last beat.
- axi_rid  in  AXI_ID_W  response ID.

Behaviour:
- Reset state, all asynchronous on rst=1:
  - state=IDLE.
  - `axi_arvalid`=0, `axi_rready`=0.
  - `cache_in_ok`=0, `cache_or_data`=32'h0.
  - armed=1, drop=0, address latch=0.
- States: IDLE, AR, R, RESP, one-hot encoded.
- IDLE:
  - If `cache_read_ena` && armed: latch `cache_addr`, clear drop, go to AR.
  - Otherwise stay.
  - armed is set whenever `cache_read_ena`=0 is sampled.
- AR:
  - `axi_arvalid`=1 from a register; `araddr` comes from the latched address.
  - `arvalid` and `araddr` stay stable until `arready`.
  - On `arvalid`&&`arready`, go to R next cycle.
- R:
  - `axi_rready`=1.
  - On `rvalid` && `rlast` && `rid`==AXI_ID: register the data lane (`addr[2]` ? `rdata[63:32]` : `rdata[31:0]`), then go to RESP.
  - A beat with a mismatched `rid` is accepted and discarded; the block stays in R.
- RESP:
  - `cache_in_ok`=1 for exactly one cycle; `cache_or_data` holds the registered word.
  - If drop=1, `cache_in_ok` stays 0.
  - armed clears; go to IDLE.
- `cache_or_data` holds its last value after RESP and changes only on R capture.
- Minimum latency: request sampled in IDLE at cycle 0, `arvalid` at cycle 1, R at cycle 2, `cache_in_ok` at cycle 3, given `arready`=1 at cycle 1 and `rvalid`=1 at cycle 2.
- Request withdrawn mid-transaction (`cache_read_ena`=0 while in AR or R):
  - Set drop.
  - Complete the AXI transaction; never drop `arvalid` before `arready`.
  - No `cache_in_ok` pulse.
- Re-arm rule: a new request is only accepted after `cache_read_ena` has been low for at least one sampled cycle following completion. This prevents a duplicate refill when the request deasserts combinationally with `cache_in_ok`.
- `rresp` non-OKAY without the optional feature: data is returned unchanged.
- Reset mid-operation: immediate IDLE, outputs at reset values; any outstanding AXI response is the interconnect's responsibility.

Optional Feature:
- ICACHE_REFILL_RESP_ERR_EN
- Defined:
  - Adds output port `cache_err` (1 bit), asserted together with `cache_in_ok`.
  - `cache_err` asserts when the captured `rresp` is SLVERR (2'b10) or DECERR (2'b11).
  - In that case `cache_or_data` is forced to 32'h0000_0013 (NOP).
- Undefined: no `cache_err` port; `rresp` is ignored.

Decomposition:
- Shared package/header (alongside the existing AXI4 defines):
  - state encodings IDLE/AR/R/RESP.
  - AXI constants: BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - NOP constant 32'h0000_0013.
- No sub-module is required. The data-lane mux and error substitution are a few lines and stay inline.

Test Plan:
- Lane select: `cache_addr`=64'h8000_0004, `arready`=1, `rvalid`=1 one cycle after the AR handshake, `rdata`=64'hAAAA_BBBB_CCCC_DDDD → `araddr`=64'h8000_0004, `cache_or_data`=32'hAAAA_BBBB, `cache_in_ok` high exactly at cycle 3.
- Backpressure: `cache_addr`=64'h8000_0000, `arready` low for 5 cycles → `arvalid` and `araddr` stable across all 5 cycles; `cache_or_data`=32'hCCCC_DDDD; exactly one `cache_in_ok` pulse.
- Re-arm: `cache_read_ena` held high for 3 cycles after `cache_in_ok` → no second `arvalid` until ena has been low for 1 cycle; then a new request is accepted.
- Withdraw: ena drops while in R with `rvalid` delayed 4 cycles → the transaction completes (`rready` handshake seen), `cache_in_ok` never asserts, state returns to IDLE.
- ID/reset: a beat with `rid`≠AXI_ID is discarded; later, rst asserted while in AR → `arvalid`=0 immediately and state is IDLE; a post-reset request works normally.
- Error response (feature on): `rresp`=2'b10 → `cache_in_ok`=1, `cache_err`=1, `cache_or_data`=32'h0000_0013.
